// File: rtl/duc_interp_ctrl_pkg.sv
// Shared types and helpers for the DUC interpolation-rate sequencer.
// Holds the FSM state encoding and the interp register word layout.
package duc_interp_ctrl_pkg;

   localparam int CP_ADDR_W = 20;

   typedef enum logic [2:0] {
      IDLE,
      FACTOR,
      CHECK,
      WR_M,
      WAIT_M,
      WR_INTERP,
      WAIT_INTERP,
      DONE
   } state_t;

   // Interp register layout: half-band count above the CIC rate.
   function automatic logic [31:0] pack_interp(input logic [7:0] hb, input logic [7:0] cic);
      return {16'h0, hb, cic};
   endfunction

endpackage

// File: rtl/duc_interp_ctrl_if.sv
// Rate request stream plus ctrlport write bus between user logic, sequencer and DUC.
// Handshakes: a rate transfers on a cycle where s_rate_tvalid && s_rate_tready; a write is a
// one-cycle m_ctrlport_req_wr strobe, completed by a later one-cycle m_ctrlport_resp_ack.
interface duc_interp_ctrl_if
   import duc_interp_ctrl_pkg::*;
#(
   parameter int RATE_W = 16
) ();

   logic [RATE_W-1:0]    s_rate_tdata;
   logic                 s_rate_tvalid;
   logic                 s_rate_tready;
   logic                 m_ctrlport_req_wr;
   logic [CP_ADDR_W-1:0] m_ctrlport_req_addr;
   logic [31:0]          m_ctrlport_req_data;
   logic                 m_ctrlport_resp_ack;

   modport master (
      input  s_rate_tdata, s_rate_tvalid, m_ctrlport_resp_ack,
      output s_rate_tready, m_ctrlport_req_wr, m_ctrlport_req_addr, m_ctrlport_req_data
   );

   modport slave (
      output s_rate_tdata, s_rate_tvalid, m_ctrlport_resp_ack,
      input  s_rate_tready, m_ctrlport_req_wr, m_ctrlport_req_addr, m_ctrlport_req_data
   );

endinterface

// File: rtl/duc_interp_ctrl_factor.sv
// Splits a requested rate into trailing half-band stages and a residual CIC rate,
// one shift per step, and flags rates the datapath cannot realise.
module duc_rate_factor #(
   parameter int NUM_HB         = 3,
   parameter int CIC_MAX_INTERP = 128,
   parameter int RATE_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [RATE_W-1:0] rate_in,
   input  logic              step,
   output logic              fin,
   output logic              illegal,
   output logic [RATE_W-1:0] rate,
   output logic [7:0]        hb,
   output logic [7:0]        cic
);

   logic [RATE_W-1:0] rate_q, rate_d;
   logic [RATE_W-1:0] rem_q, rem_d;
   logic [7:0]        hb_q, hb_d;
   logic              can_shift;

   assign can_shift = (rem_q[0] == 1'b0) && (hb_q < 8'(NUM_HB));

   always_comb begin
      rate_d = rate_q;
      rem_d  = rem_q;
      hb_d   = hb_q;
      if (start) begin
         rate_d = rate_in;
         rem_d  = rate_in;
         hb_d   = 8'd0;
      end else if (step && can_shift) begin
         rem_d = rem_q >> 1;
         hb_d  = hb_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rate_q <= '0;
         rem_q  <= '0;
         hb_q   <= 8'd0;
      end else begin
         rate_q <= rate_d;
         rem_q  <= rem_d;
         hb_q   <= hb_d;
      end
   end

   // A zero residue also covers rate 0 once the half-band cap stops the shifting.
   assign fin     = !can_shift;
   assign illegal = (rate_q == '0) || (rem_q > RATE_W'(CIC_MAX_INTERP)) || (rem_q == '0);
   assign rate    = rate_q;
   assign hb      = hb_q;
   assign cic     = rem_q[7:0];

endmodule

// File: rtl/duc_interp_ctrl.sv
// Sequencer: factors a requested interpolation rate, then writes the rate-change M
// register and the interp register over ctrlport, with an ack timeout on each write.
module duc_interp_ctrl
   import duc_interp_ctrl_pkg::*;
#(
   parameter int                   NUM_HB         = 3,
   parameter int                   CIC_MAX_INTERP = 128,
   parameter int                   RATE_W         = 16,
   parameter logic [CP_ADDR_W-1:0] SR_M_ADDR      = 20'h00080,
   parameter logic [CP_ADDR_W-1:0] SR_INTERP_ADDR = 20'h00088,
   parameter int                   ACK_TIMEOUT    = 1023
) (
   input  logic                     ce_clk,
   input  logic                     ce_rst,
   duc_interp_ctrl_if.master        bus,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [7:0]               hb_enables,
   output logic [7:0]               cic_rate,
   output state_t                   dbg_state
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0]           cic_q, cic_d;
   logic                 req_wr_q, req_wr_d;
   logic [CP_ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]          data_q, data_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [7:0]           hb_en_q, hb_en_d;
   logic [7:0]           cic_rate_q, cic_rate_d;

   logic                 fac_start, fac_step, fac_fin, fac_illegal;
   logic [RATE_W-1:0]    fac_rate;
   logic [7:0]           fac_hb, fac_cic;
   logic                 ack_to;

   duc_rate_factor #(
      .NUM_HB(NUM_HB), .CIC_MAX_INTERP(CIC_MAX_INTERP), .RATE_W(RATE_W)
   ) u_factor (
      .clk(ce_clk), .rst(ce_rst), .start(fac_start), .rate_in(bus.s_rate_tdata),
      .step(fac_step), .fin(fac_fin), .illegal(fac_illegal), .rate(fac_rate),
      .hb(fac_hb), .cic(fac_cic)
   );

   // The counter starts at zero on the first wait cycle, so the final wait cycle holds ACK_TIMEOUT-1.
   assign ack_to = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cic_d      = cic_q;
      req_wr_d   = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      hb_en_d    = hb_en_q;
      cic_rate_d = cic_rate_q;
      fac_start  = 1'b0;
      fac_step   = 1'b0;
      case (state_q)
         IDLE: if (bus.s_rate_tvalid) begin
            fac_start = 1'b1;
            state_d   = FACTOR;
         end
         FACTOR: if (fac_fin) state_d = CHECK;
                 else         fac_step = 1'b1;
         CHECK: if (fac_illegal) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end else begin
            cic_d    = fac_cic;
            state_d  = WR_M;
            req_wr_d = 1'b1;
            addr_d   = SR_M_ADDR;
            data_d   = 32'(fac_rate);
         end
         WR_M: begin
            state_d = WAIT_M;
            cnt_d   = '0;
         end
         WAIT_M: if (bus.m_ctrlport_resp_ack) begin
            state_d  = WR_INTERP;
            req_wr_d = 1'b1;
            addr_d   = SR_INTERP_ADDR;
            data_d   = pack_interp(fac_hb, cic_q);
         end else if (ack_to) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end else cnt_d = cnt_q + 1'b1;
         WR_INTERP: begin
            state_d = WAIT_INTERP;
            cnt_d   = '0;
         end
         WAIT_INTERP: if (bus.m_ctrlport_resp_ack) begin
            hb_en_d    = fac_hb;
            cic_rate_d = cic_q;
            state_d    = DONE;
            done_d     = 1'b1;
         end else if (ack_to) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end else cnt_d = cnt_q + 1'b1;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ce_clk) begin
      if (ce_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cic_q      <= 8'd1;
         req_wr_q   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         hb_en_q    <= 8'd0;
         cic_rate_q <= 8'd1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cic_q      <= cic_d;
         req_wr_q   <= req_wr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         done_q     <= done_d;
         err_q      <= err_d;
         hb_en_q    <= hb_en_d;
         cic_rate_q <= cic_rate_d;
      end
   end

   assign bus.s_rate_tready       = (state_q == IDLE);
   assign bus.m_ctrlport_req_wr   = req_wr_q;
   assign bus.m_ctrlport_req_addr = addr_q;
   assign bus.m_ctrlport_req_data = data_q;
   assign busy                    = (state_q != IDLE);
   assign done                    = done_q;
   assign err                     = err_q;
   assign hb_enables              = hb_en_q;
   assign cic_rate                = cic_rate_q;
   assign dbg_state               = state_q;

endmodule

// File: tb/tb_duc_interp_ctrl.sv
// Directed bench for duc_interp_ctrl: rate requests with hand-computed ctrlport writes,
// rejection, ack timeout, mid-sequence reset and spurious acks.
module tb_duc_interp_ctrl;
   import duc_interp_ctrl_pkg::*;

   logic       ce_clk;
   logic       ce_rst;
   logic       busy, done, err;
   logic [7:0] hb_enables, cic_rate;
   state_t     dbg_state;

   duc_interp_ctrl_if #(.RATE_W(16)) bus ();

   duc_interp_ctrl #(
      .NUM_HB(3), .CIC_MAX_INTERP(128), .RATE_W(16),
      .SR_M_ADDR(20'h00080), .SR_INTERP_ADDR(20'h00088), .ACK_TIMEOUT(1023)
   ) dut (
      .ce_clk(ce_clk), .ce_rst(ce_rst), .bus(bus), .busy(busy), .done(done), .err(err),
      .hb_enables(hb_enables), .cic_rate(cic_rate), .dbg_state(dbg_state)
   );

   // clock / reset
   initial ce_clk = 1'b0;
   always #5 ce_clk = ~ce_clk;

   // scoreboard
   logic [51:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   int r_done, r_err, r_nwr, r_tready_hi, r_wr1_cyc, r_done_cyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input logic [19:0] addr, input logic [31:0] data);
      exp_q.push_back({addr, data});
   endtask

   // driver: present one rate and return one cycle after the accepting edge
   task automatic accept_rate(input logic [15:0] rate);
      int n;
      n = 0;
      @(negedge ce_clk);
      while (!bus.s_rate_tready && n < 200) begin
         @(negedge ce_clk);
         n++;
      end
      chk("accept_ready", 64'(bus.s_rate_tready), 64'd1);
      @(posedge ce_clk); #1;
      bus.s_rate_tdata  = rate;
      bus.s_rate_tvalid = 1'b1;
      @(posedge ce_clk); #1;
      bus.s_rate_tvalid = 1'b0;
   endtask

   // driver + monitor: ack each write ack_dly cycles later, check writes, stop at done
   task automatic run_req(input int ack_dly, input bit give_ack, input int stop_after_wr);
      int ack_cd;
      ack_cd = -1;
      r_done = 0; r_err = 0; r_nwr = 0; r_tready_hi = 0; r_wr1_cyc = 0; r_done_cyc = 0;
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         @(negedge ce_clk);
         if (bus.s_rate_tready) r_tready_hi++;
         if (bus.m_ctrlport_req_wr) begin
            r_nwr++;
            if (r_nwr == 1) r_wr1_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("unexpected_wr", 64'({bus.m_ctrlport_req_addr, bus.m_ctrlport_req_data}), 64'd0);
            end else begin
               chk("wr_addr_data", 64'({bus.m_ctrlport_req_addr, bus.m_ctrlport_req_data}),
                   64'(exp_q.pop_front()));
            end
            if (give_ack) ack_cd = ack_dly;
            if (r_nwr == stop_after_wr) break;
         end
         if (done) begin
            r_done = 1;
            r_err = int'(err);
            r_done_cyc = cyc;
            break;
         end
         @(posedge ce_clk); #1;
         if (ack_cd > 0) ack_cd--;
         bus.m_ctrlport_resp_ack = (ack_cd == 0);
         if (ack_cd == 0) ack_cd = -1;
      end
      bus.m_ctrlport_resp_ack = 1'b0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_state"},  64'(dbg_state), 64'(IDLE));
      chk({tag, "_tready"}, 64'(bus.s_rate_tready), 64'd1);
      chk({tag, "_wr"},     64'(bus.m_ctrlport_req_wr), 64'd0);
      chk({tag, "_addr"},   64'(bus.m_ctrlport_req_addr), 64'd0);
      chk({tag, "_data"},   64'(bus.m_ctrlport_req_data), 64'd0);
      chk({tag, "_busy"},   64'(busy), 64'd0);
      chk({tag, "_done"},   64'(done), 64'd0);
      chk({tag, "_err"},    64'(err), 64'd0);
      chk({tag, "_hb"},     64'(hb_enables), 64'd0);
      chk({tag, "_cic"},    64'(cic_rate), 64'd1);
   endtask

   initial begin
      ce_rst = 1'b1;
      bus.s_rate_tdata = '0;
      bus.s_rate_tvalid = 1'b0;
      bus.m_ctrlport_resp_ack = 1'b0;
      repeat (3) @(posedge ce_clk);
      @(negedge ce_clk);
      chk_reset_values("rst0");
      @(posedge ce_clk); #1;
      ce_rst = 1'b0;

      // rate 12 = 4 * 3 : 2 half-bands, CIC 3
      push_wr(20'h00080, 32'd12);
      push_wr(20'h00088, 32'h0000_0203);
      accept_rate(16'd12);
      run_req(2, 1'b1, 0);
      chk("r12_done", 64'(r_done), 64'd1);
      chk("r12_err", 64'(r_err), 64'd0);
      chk("r12_nwr", 64'(r_nwr), 64'd2);
      chk("r12_latency", 64'(r_done_cyc), 64'd11);
      @(negedge ce_clk);
      chk("r12_hb", 64'(hb_enables), 64'd2);
      chk("r12_cic", 64'(cic_rate), 64'd3);
      chk("r12_done_pulse", 64'(done), 64'd0);
      chk("r12_err_clear", 64'(err), 64'd0);

      // rate 0 rejected after the half-band cap is reached
      accept_rate(16'd0);
      run_req(2, 1'b1, 0);
      chk("r0_done", 64'(r_done), 64'd1);
      chk("r0_err", 64'(r_err), 64'd1);
      chk("r0_nwr", 64'(r_nwr), 64'd0);
      chk("r0_latency", 64'(r_done_cyc), 64'd6);

      // rate 2048: 3 half-bands leave CIC 256, above the CIC limit
      accept_rate(16'd2048);
      run_req(2, 1'b1, 0);
      chk("r2048_done", 64'(r_done), 64'd1);
      chk("r2048_err", 64'(r_err), 64'd1);
      chk("r2048_nwr", 64'(r_nwr), 64'd0);
      @(negedge ce_clk);
      chk("rej_hb_kept", 64'(hb_enables), 64'd2);
      chk("rej_cic_kept", 64'(cic_rate), 64'd3);

      // rate 40 then 13 back to back
      push_wr(20'h00080, 32'd40);
      push_wr(20'h00088, 32'h0000_0305);
      accept_rate(16'd40);
      run_req(2, 1'b1, 0);
      chk("r40_done", 64'(r_done), 64'd1);
      chk("r40_err", 64'(r_err), 64'd0);
      chk("r40_tready_low", 64'(r_tready_hi), 64'd0);
      push_wr(20'h00080, 32'd13);
      push_wr(20'h00088, 32'h0000_000D);
      accept_rate(16'd13);
      run_req(2, 1'b1, 0);
      chk("r13_done", 64'(r_done), 64'd1);
      chk("r13_err", 64'(r_err), 64'd0);
      @(negedge ce_clk);
      chk("r13_hb", 64'(hb_enables), 64'd0);
      chk("r13_cic", 64'(cic_rate), 64'd13);

      // rate 8: first write never acked
      push_wr(20'h00080, 32'd8);
      accept_rate(16'd8);
      run_req(2, 1'b0, 0);
      chk("to_done", 64'(r_done), 64'd1);
      chk("to_err", 64'(r_err), 64'd1);
      chk("to_nwr", 64'(r_nwr), 64'd1);
      chk("to_wait_len", 64'(r_done_cyc - (r_wr1_cyc + 1)), 64'd1023);
      chk("to_latency", 64'(r_done_cyc), 64'd1030);
      @(negedge ce_clk);
      chk("to_hb_kept", 64'(hb_enables), 64'd0);
      chk("to_cic_kept", 64'(cic_rate), 64'd13);

      // rate 6, reset while waiting for the interp ack, ack arrives just after reset
      push_wr(20'h00080, 32'd6);
      push_wr(20'h00088, 32'h0000_0103);
      accept_rate(16'd6);
      run_req(2, 1'b1, 2);
      chk("rst_reached_wr2", 64'(r_nwr), 64'd2);
      @(posedge ce_clk); #1;
      chk("rst_in_wait", 64'(dbg_state), 64'(WAIT_INTERP));
      ce_rst = 1'b1;
      @(posedge ce_clk); #1;
      ce_rst = 1'b0;
      bus.m_ctrlport_resp_ack = 1'b1;
      @(negedge ce_clk);
      chk_reset_values("rst1");
      @(posedge ce_clk); #1;
      bus.m_ctrlport_resp_ack = 1'b0;
      @(negedge ce_clk);
      chk_reset_values("rst_late_ack");

      // rate 1 after reset
      push_wr(20'h00080, 32'd1);
      push_wr(20'h00088, 32'h0000_0001);
      accept_rate(16'd1);
      run_req(2, 1'b1, 0);
      chk("r1_done", 64'(r_done), 64'd1);
      chk("r1_err", 64'(r_err), 64'd0);
      @(negedge ce_clk);
      chk("r1_cic", 64'(cic_rate), 64'd1);

      // spurious ack in IDLE
      @(posedge ce_clk); #1;
      bus.m_ctrlport_resp_ack = 1'b1;
      @(negedge ce_clk);
      @(posedge ce_clk); #1;
      @(negedge ce_clk);
      chk("sp_idle_state", 64'(dbg_state), 64'(IDLE));
      chk("sp_idle_done", 64'(done), 64'd0);
      chk("sp_idle_busy", 64'(busy), 64'd0);
      @(posedge ce_clk); #1;
      bus.m_ctrlport_resp_ack = 1'b0;

      // spurious ack across FACTOR and CHECK for rate 3
      push_wr(20'h00080, 32'd3);
      push_wr(20'h00088, 32'h0000_0003);
      accept_rate(16'd3);
      bus.m_ctrlport_resp_ack = 1'b1;
      @(negedge ce_clk);
      chk("sp_factor_state", 64'(dbg_state), 64'(FACTOR));
      @(posedge ce_clk); #1;
      @(negedge ce_clk);
      chk("sp_check_state", 64'(dbg_state), 64'(CHECK));
      chk("sp_check_done", 64'(done), 64'd0);
      @(posedge ce_clk); #1;
      bus.m_ctrlport_resp_ack = 1'b0;
      run_req(2, 1'b1, 0);
      chk("r3_done", 64'(r_done), 64'd1);
      chk("r3_err", 64'(r_err), 64'd0);
      chk("r3_nwr", 64'(r_nwr), 64'd2);
      @(negedge ce_clk);
      chk("r3_hb", 64'(hb_enables), 64'd0);
      chk("r3_cic", 64'(cic_rate), 64'd3);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
